// File: rtl/mem_sweep_initiator.sv
// Memory sweep initiator: writes P(i)=SEED^i to every word, reads it back and compares.
// Optional macro MEM_SWEEP_INVERT_PASS_EN adds a second write/read pass using ~P(i).
module mem_sweep_initiator #(
  parameter int          WIDTH      = 8,
  parameter int          DEPTH      = 16,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [31:0] SEED       = 32'hA5,
  parameter int          TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [ADDR_WIDTH+1:0] o_err_count,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic                  o_valid,
  output logic                  o_wr_rd,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [WIDTH-1:0]      o_wdata,
  input  logic                  i_ready,
  input  logic [WIDTH-1:0]      i_rdata
);
  localparam int                    WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0]      SEED_W = WIDTH'(SEED);
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_L = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ,
`ifdef MEM_SWEEP_INVERT_PASS_EN
    S_WRITE_INV, S_READ_INV,
`endif
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [WIDTH-1:0] p;
    p = SEED_W ^ WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  state_t                r_state;
  logic                  r_busy, r_done, r_pass, r_timeout, r_valid, r_wr_rd, r_err_seen;
  logic [ADDR_WIDTH+1:0] r_err_count;
  logic [ADDR_WIDTH-1:0] r_err_addr, r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WAIT_W-1:0]     r_wait;

  logic                  w_hs, w_rd, w_inv, w_mis;
  logic [ADDR_WIDTH+1:0] w_err_inc, w_err_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // r_wdata keeps the current pattern during reads too, so it doubles as the compare value
  always_comb begin
    w_rd  = (r_state == S_READ);
    w_inv = 1'b0;
`ifdef MEM_SWEEP_INVERT_PASS_EN
    w_rd  = w_rd || (r_state == S_READ_INV);
    w_inv = (r_state == S_WRITE_INV) || (r_state == S_READ_INV);
`endif
    w_hs       = r_valid && i_ready;
    w_mis      = w_rd && (i_rdata != r_wdata);
    w_err_inc  = (r_err_count == '1) ? r_err_count : r_err_count + 1'b1;
    w_err_nxt  = (w_hs && w_mis) ? w_err_inc : r_err_count;
    w_addr_nxt = r_addr + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_valid     <= 1'b0;
      r_wr_rd     <= 1'b0;
      r_err_seen  <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state     <= S_WRITE;
          r_busy      <= 1'b1;
          r_valid     <= 1'b1;
          r_wr_rd     <= 1'b1;
          r_addr      <= '0;
          r_wdata     <= pat('0, 1'b0);
          r_pass      <= 1'b0;
          r_timeout   <= 1'b0;
          r_err_count <= '0;
          r_err_addr  <= '0;
          r_err_seen  <= 1'b0;
          r_wait      <= '0;
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          if (w_hs) begin
            r_wait <= '0;
            if (w_mis) begin
              r_err_count <= w_err_inc;
              if (!r_err_seen) begin
                r_err_addr <= r_addr;
                r_err_seen <= 1'b1;
              end
            end
            if (r_addr == LAST) begin
              r_addr <= '0;
              case (r_state)
                S_WRITE: begin r_state <= S_READ; r_wr_rd <= 1'b0; r_wdata <= pat('0, 1'b0); end
`ifdef MEM_SWEEP_INVERT_PASS_EN
                S_READ: begin r_state <= S_WRITE_INV; r_wr_rd <= 1'b1; r_wdata <= pat('0, 1'b1); end
                S_WRITE_INV: begin r_state <= S_READ_INV; r_wr_rd <= 1'b0; r_wdata <= pat('0, 1'b1); end
`endif
                default: begin
                  r_state <= S_DONE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nxt == '0);
                end
              endcase
            end else begin
              r_addr  <= w_addr_nxt;
              r_wdata <= pat(w_addr_nxt, w_inv);
            end
          end else if (r_wait == WAIT_L) begin
            // abort the sweep; addr/wdata are left where the stall happened
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;
  assign o_valid     = r_valid;
  assign o_wr_rd     = r_wr_rd;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
endmodule

// File: tb/tb_mem_sweep_initiator.sv
// Scoreboard bench for mem_sweep_initiator: responder model, per-transfer and per-sweep checks.
module tb_mem_sweep_initiator;
  localparam int W = 8, D = 16, AW = 4, TO = 8;
`ifdef MEM_SWEEP_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ready = 1'b0;
  logic busy, done, pass, tmo, valid, wr_rd;
  logic [AW+1:0] err_count;
  logic [AW-1:0] err_addr, addr;
  logic [W-1:0]  wdata, rdata;

  always #5 clk = ~clk;

  mem_sweep_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .SEED(32'hA5), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_timeout(tmo), .o_err_count(err_count), .o_err_addr(err_addr), .o_valid(valid),
    .o_wr_rd(wr_rd), .o_addr(addr), .o_wdata(wdata), .i_ready(ready), .i_rdata(rdata));

  logic [W-1:0] mem [D];
  bit corrupt = 1'b0;
  assign rdata = mem[addr] ^ ((corrupt && (addr == 4'd5 || addr == 4'd9)) ? 8'hFF : 8'h00);
  always @(posedge clk) if (valid && ready && wr_rd) mem[addr] <= wdata;

  typedef struct { bit wr; logic [AW-1:0] a; logic [W-1:0] d; } xact_t;
  typedef struct { bit pass; bit to; logic [AW+1:0] ec; logic [AW-1:0] ea; int hs; } res_t;
  xact_t xq[$];
  res_t  rq[$];
  int n_cmp = 0, n_err = 0, cyc = 0, start_cyc = 0, stalls = 0, hs_cnt = 0, mode = 0, zrun = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // responder ready: 0 ideal, 1 random with at most 3 stalls in a row, 2 stall from the third transfer
  always @(posedge clk) begin
    #1;
    case (mode)
      1: if (zrun >= 3 || $urandom_range(0, 1) == 1) begin ready = 1'b1; zrun = 0; end
         else begin ready = 1'b0; zrun++; end
      2: ready = (hs_cnt < 2);
      default: ready = 1'b1;
    endcase
  end

  // monitor: transfer scoreboard, stall stability, end-of-sweep results
  bit pstall = 1'b0;
  logic [AW-1:0] pa;
  logic [W-1:0]  pd;
  bit pw;
  always @(negedge clk) begin
    xact_t x;
    res_t r;
    if (pstall && valid) begin
      chk("hold_addr", 32'(addr), 32'(pa));
      chk("hold_wdata", 32'(wdata), 32'(pd));
      chk("hold_wr_rd", 32'(wr_rd), 32'(pw));
    end
    pstall = rst && valid && !ready;
    pa = addr; pd = wdata; pw = wr_rd;
    if (valid && !ready) stalls++;
    if (valid && ready) begin
      hs_cnt++;
      if (xq.size() == 0) chk("xact_unexpected", 1, 0);
      else begin
        x = xq.pop_front();
        chk("xact_wr_rd", 32'(wr_rd), 32'(x.wr));
        chk("xact_addr", 32'(addr), 32'(x.a));
        if (x.wr) chk("xact_wdata", 32'(wdata), 32'(x.d));
      end
    end
    if (done) begin
      if (rq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        r = rq.pop_front();
        chk("res_pass", 32'(pass), 32'(r.pass));
        chk("res_timeout", 32'(tmo), 32'(r.to));
        chk("res_err_count", 32'(err_count), 32'(r.ec));
        chk("res_err_addr", 32'(err_addr), 32'(r.ea));
        chk("res_busy_low", 32'(busy), 0);
        chk("res_valid_low", 32'(valid), 0);
        chk("latency", 32'(cyc - start_cyc + 1), 32'(r.hs + stalls + 1));
      end
    end
  end

  function automatic logic [W-1:0] pat(input int i, input bit inv);
    logic [W-1:0] p;
    p = 8'hA5 ^ W'(i);
    return inv ? ~p : p;
  endfunction

  task automatic push_sweep(input int nwr);
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < nwr; i++) xq.push_back('{1'b1, AW'(i), pat(i, p == 1)});
      if (nwr == D) for (int i = 0; i < D; i++) xq.push_back('{1'b0, AW'(i), pat(i, p == 1)});
    end
  endtask

  task automatic go();
    @(negedge clk);
    hs_cnt = 0; stalls = 0; start = 1'b1;
    @(negedge clk);
    start_cyc = cyc; start = 1'b0;
  endtask

  task automatic wait_res();
    int t = 0;
    while (rq.size() != 0 && t < 600) begin @(negedge clk); #1; t++; end
    if (rq.size() != 0) begin chk("done_wait", 0, 1); rq.delete(); xq.delete(); end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_err_addr"}, 32'(err_addr), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_wr_rd"}, 32'(wr_rd), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_wdata"}, 32'(wdata), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    #3 chk_reset_vals("rst0");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // ideal responder
    mode = 0; push_sweep(D); rq.push_back('{1'b1, 1'b0, '0, '0, 2 * D * NPASS});
    go(); wait_res();

    // random stalls
    mode = 1; push_sweep(D); rq.push_back('{1'b1, 1'b0, '0, '0, 2 * D * NPASS});
    go(); wait_res();

    // corrupted reads at 5 and 9
    mode = 0; corrupt = 1'b1; push_sweep(D);
    rq.push_back('{1'b0, 1'b0, (AW+2)'(2 * NPASS), 4'd5, 2 * D * NPASS});
    go(); wait_res(); corrupt = 1'b0;

    // ready stuck low from the third write
    mode = 2; push_sweep(2); rq.push_back('{1'b0, 1'b1, '0, '0, 2});
    go(); wait_res();
    chk("to_addr_stop", 32'(addr), 2);
    chk("to_valid_low", 32'(valid), 0);
    chk("to_stall_cycles", 32'(stalls), TO);
    mode = 0;
    repeat (2) @(negedge clk);

    // reset mid-READ
    push_sweep(D); rq.push_back('{1'b1, 1'b0, '0, '0, 2 * D * NPASS});
    go();
    t = 0;
    while (hs_cnt < D + 3 && t < 200) begin @(negedge clk); t++; end
    chk("mid_read_reached", 32'(hs_cnt >= D + 3), 1);
    chk("mid_read_is_read", 32'(wr_rd), 0);
    #2 rst = 1'b0;
    #1 chk_reset_vals("rst_mid");
    xq.delete(); rq.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // fresh sweep after reset; a start pulse while busy must be ignored
    push_sweep(D); rq.push_back('{1'b1, 1'b0, '0, '0, 2 * D * NPASS});
    go();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_start", 32'(busy), 1);
    wait_res();
    repeat (4) @(negedge clk);
    chk("xq_empty", 32'(xq.size()), 0);
    chk("idle_after", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_sweep_initiator.md
# mem_sweep_initiator

Synthesizable initiator for the single-port memory's valid/ready request interface (`addr`, `wdata`, `wr_rd`, `valid`, `ready`, `rdata`). On `start` it writes a deterministic pattern to every location, reads every location back and compares the result. It reports pass/fail, an error count, the first failing address and a handshake timeout. It sits between a control/status host and the memory, and serves as a power-on memory check and as the in-system counterpart of the memory responder.

## Interface
- `WIDTH`, 8, data width
- `DEPTH`, 16, number of words swept
- `ADDR_WIDTH`, 4, address width; DEPTH ≤ 2^ADDR_WIDTH
- `SEED`, 8'hA5 (zero-extended/truncated to WIDTH), pattern seed
- `TIMEOUT`, 64, maximum cycles to wait for `ready` on one transfer
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: begin sweep, sampled only in IDLE
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse at sweep end
- `pass` out 1: last sweep had no errors and no timeout; held until next start
- `timeout` out 1: last sweep aborted on timeout; held until next start
- `err_count` out ADDR_WIDTH+2: mismatch count, saturating
- `err_addr` out ADDR_WIDTH: address of first mismatch
- `valid` out 1: request valid
- `wr_rd` out 1: 1 = write, 0 = read
- `addr` out ADDR_WIDTH: request address
- `wdata` out WIDTH: write data
- `ready` in 1: responder accepts or completes the request
- `rdata` in WIDTH: read data, valid on read handshake edge

## Operation
- Pattern: P(i) = SEED ^ i (i zero-extended to WIDTH). Inverted pass uses ~P(i).
- FSM states: IDLE, WRITE, READ, WRITE_INV, READ_INV, DONE.
  - IDLE: `start`=1 → WRITE. Counters and flags clear.
  - WRITE: on the handshake at i = DEPTH-1 → READ.
  - READ: on the handshake at i = DEPTH-1 → WRITE_INV if the macro is defined, otherwise DONE.
  - WRITE_INV → READ_INV → DONE, with the same sweep rules.
  - DONE: lasts one cycle, `done`=1, then → IDLE.
- Handshake: a transfer completes on a posedge where `valid`&&`ready`. While `valid`=1 and `ready`=0, `addr`, `wdata` and `wr_rd` hold stable. Back-to-back transfers are allowed: `valid` stays high and `addr` increments on the cycle after each handshake.
- Read compare: at the read handshake edge, `rdata` is compared with the expected value.
  - On mismatch, `err_count` increments, saturating at all-ones.
  - On the first mismatch of the sweep, `err_addr` is captured.
- Timeout: a wait counter resets on every handshake and increments every cycle `valid`=1 and `ready`=0. When it reaches TIMEOUT: `timeout`=1, `valid` drops, FSM → DONE. Remaining addresses are skipped.
- `pass` = (`err_count`==0)&&!`timeout`, registered on entry to DONE.
- `start` while busy is ignored. `start` held high re-triggers a sweep only after returning to IDLE.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous). No partial result is retained.
- Reset values: `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `err_addr`=0, `valid`=0, `wr_rd`=0, `addr`=0, `wdata`=0; FSM = IDLE.

## Timing
- `start` sampled at edge k. From edge k: `busy`=1, `valid`=1, `wr_rd`=1, `addr`=0, `wdata`=P(0).
- With `ready` constantly 1:
  - Writes complete at edges k+1..k+DEPTH.
  - Reads complete at edges k+DEPTH+1..k+2·DEPTH.
  - `done`=1 and `busy`=0 in the cycle after edge k+2·DEPTH.
  - Start-to-done is 2·DEPTH+1 cycles; with INV pass, 4·DEPTH+1.
- Each `ready`=0 cycle adds one cycle of latency.
- `err_count`, `err_addr`, `pass` and `timeout` are valid when `done`=1 and hold until the next `start`.
- `valid`=0 in IDLE and DONE.

## Configuration
- `MEM_SWEEP_INVERT_PASS_EN` defined: after READ, adds WRITE_INV/READ_INV passes with ~P(i), so every bit is exercised at both values. `err_count` accumulates across both passes.
- Not defined: single write/read pass only, and the INV states are not synthesized.

## Test plan
- DEPTH=16, SEED=8'hA5, ideal responder (`ready`=1), macro off:
  - Response: 16 writes of A5^i, then 16 reads.
  - `done` 33 cycles after start, `pass`=1, `err_count`=0.
- Responder deasserts `ready` randomly, ~50%:
  - Response: `addr`, `wdata` and `wr_rd` stable during every stall.
  - Same final result.
  - Start-to-done = 33 + stall cycles.
- Responder corrupts `rdata` at addr 5 and addr 9:
  - `pass`=0, `err_count`=2, `err_addr`=5.
- TIMEOUT=8, `ready` forced 0 from the third write:
  - `valid` drops after 8 stall cycles.
  - `timeout`=1, `done` pulses, `pass`=0, `addr` stops at 2.
- `rst` low mid-READ, then `start` pulsed while busy:
  - Reset: all outputs return to reset values asynchronously.
  - After release, the new sweep starts at addr 0 and passes.
  - The `start` pulse during busy has no effect.
- Macro on, ideal responder:
  - Second write pass uses 5A^i.
  - `done` 65 cycles after start, `pass`=1.
